// File: rtl/arm_shift_pkg.sv
// Shared types and instruction-class codes for the ARM operand-2 shifter pipeline.
package arm_shift_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_t;

  localparam logic [2:0] CLS_DP_REG = 3'b000;
  localparam logic [2:0] CLS_DP_IMM = 3'b001;
  localparam logic [2:0] CLS_LS_IMM = 3'b010;
  localparam logic [2:0] CLS_LS_REG = 3'b011;
  localparam logic [2:0] CLS_BR     = 3'b101;

  // Decoded request held in the first pipeline stage.
  typedef struct packed {
    shift_t          stype;
    logic [7:0]      amt;
    logic [XLEN-1:0] operand;
    logic            c_in;
    logic            rrx;
    logic            bypass;
    logic [2:0]      kind;
  } s1_t;

endpackage

// File: rtl/arm_barrel_core.sv
// Combinational ARM barrel shifter: all zero-amount, >=32 and RRX rules live here.
module arm_barrel_core
  import arm_shift_pkg::*;
(
  input  logic [XLEN-1:0] operand,
  input  logic [7:0]      amt,
  input  shift_t          stype,
  input  logic            c_in,
  input  logic            rrx,
  output logic [XLEN-1:0] out,
  output logic            cout
);

  logic [4:0]      sh;
  logic            is32;
  logic            big;
  logic [XLEN:0]   lsl_w;
  logic [XLEN:0]   lsr_w;
  logic [XLEN:0]   asr_w;
  logic [XLEN-1:0] ror_v;

  always_comb begin
    sh    = amt[4:0];
    is32  = (amt == 8'd32);
    big   = (amt > 8'd32);
    // One extra bit on the shifted-out side captures the carry directly.
    lsl_w = {1'b0, operand} << sh;
    lsr_w = {operand, 1'b0} >> sh;
    asr_w = $signed({operand, 1'b0}) >>> sh;
    ror_v = (operand >> sh) | (operand << (6'd32 - {1'b0, sh}));

    out  = operand;
    cout = c_in;
    if (rrx) begin
      out  = {c_in, operand[XLEN-1:1]};
      cout = operand[0];
    end else if (amt != 8'd0) begin
      unique case (stype)
        LSL: begin
          if (is32) begin
            out  = '0;
            cout = operand[0];
          end else if (big) begin
            out  = '0;
            cout = 1'b0;
          end else begin
            out  = lsl_w[XLEN-1:0];
            cout = lsl_w[XLEN];
          end
        end
        LSR: begin
          if (is32) begin
            out  = '0;
            cout = operand[XLEN-1];
          end else if (big) begin
            out  = '0;
            cout = 1'b0;
          end else begin
            out  = lsr_w[XLEN:1];
            cout = lsr_w[0];
          end
        end
        ASR: begin
          if (is32 || big) begin
            out  = {XLEN{operand[XLEN-1]}};
            cout = operand[XLEN-1];
          end else begin
            out  = asr_w[XLEN:1];
            cout = asr_w[0];
          end
        end
        ROR: begin
          if (sh == 5'd0) begin
            out  = operand;
            cout = operand[XLEN-1];
          end else begin
            out  = ror_v;
            cout = ror_v[XLEN-1];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/arm_operand2_pipe.sv
// Handshaked operand-2 pipeline: decode of the instruction class, then the barrel core,
// registered over one or two stages with flush and backpressure.
module arm_operand2_pipe
  import arm_shift_pkg::*;
#(
  parameter int PIPE   = 2,
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] ir,
  input  logic [31:0] rm,
  input  logic [31:0] rs,
  input  logic        c_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        shift_cout,
  output logic [2:0]  out_kind
);

  if (PIPE != 1 && PIPE != 2) begin : g_bad_pipe
    $error("arm_operand2_pipe: PIPE must be 1 or 2, got %0d", PIPE);
  end
  if (DATA_W != XLEN) begin : g_bad_width
    $error("arm_operand2_pipe: DATA_W must be 32, got %0d", DATA_W);
  end

  s1_t        dec;
  logic [4:0] imm_n;
  logic [7:0] imm_amt;
  logic       imm_rrx;
  logic       unused_bits;

  assign unused_bits = ^{ir[31:28], ir[24], rs[31:8]};

  // Immediate #0 encodings are folded into amt=32 or RRX so the core sees one rule set.
  always_comb begin
    imm_n   = ir[11:7];
    imm_amt = {3'b000, imm_n};
    imm_rrx = 1'b0;
    if (imm_n == 5'd0) begin
      unique case (shift_t'(ir[6:5]))
        LSL:      imm_amt = 8'd0;
        LSR, ASR: imm_amt = 8'd32;
        ROR:      imm_rrx = 1'b1;
      endcase
    end

    dec         = '0;
    dec.stype   = shift_t'(ir[6:5]);
    dec.operand = rm;
    dec.c_in    = c_in;
    dec.kind    = ir[27:25];
    dec.bypass  = 1'b1;
    case (ir[27:25])
      CLS_DP_REG: begin
        if (!ir[4]) begin
          dec.bypass = 1'b0;
          dec.amt    = imm_amt;
          dec.rrx    = imm_rrx;
        end else if (!ir[7]) begin
          dec.bypass = 1'b0;
          dec.amt    = rs[7:0];
        end
      end
      CLS_LS_REG: begin
        dec.bypass = 1'b0;
        dec.amt    = imm_amt;
        dec.rrx    = imm_rrx;
      end
      CLS_DP_IMM: begin
        dec.bypass  = 1'b0;
        dec.stype   = ROR;
        dec.operand = {24'd0, ir[7:0]};
        dec.amt     = {3'b000, ir[11:8], 1'b0};
      end
      CLS_LS_IMM: dec.operand = {20'd0, ir[11:0]};
      CLS_BR:     dec.operand = {{6{ir[23]}}, ir[23:0], 2'b00};
      default:    ;
    endcase
  end

  if (PIPE == 1) begin : g_pipe1
    logic [31:0] core_out;
    logic        core_cout;

    arm_barrel_core u_core (
      .operand (dec.operand),
      .amt     (dec.bypass ? 8'd0 : dec.amt),
      .stype   (dec.stype),
      .c_in    (dec.c_in),
      .rrx     (dec.rrx && !dec.bypass),
      .out     (core_out),
      .cout    (core_cout)
    );

    assign in_ready = !flush && (!out_valid || out_ready);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid  <= 1'b0;
        out        <= '0;
        shift_cout <= 1'b0;
        out_kind   <= '0;
      end else if (flush) begin
        out_valid <= 1'b0;
      end else if (!out_valid || out_ready) begin
        out_valid <= in_valid;
        if (in_valid) begin
          out        <= core_out;
          shift_cout <= core_cout;
          out_kind   <= dec.kind;
        end
      end
    end
  end else begin : g_pipe2
    s1_t         s1;
    logic        s1_valid;
    logic        s2_load;
    logic [31:0] core_out;
    logic        core_cout;

    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !flush && (!s1_valid || s2_load);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid <= 1'b0;
        s1       <= '0;
      end else if (flush) begin
        s1_valid <= 1'b0;
      end else if (!s1_valid || s2_load) begin
        s1_valid <= in_valid;
        if (in_valid) s1 <= dec;
      end
    end

    arm_barrel_core u_core (
      .operand (s1.operand),
      .amt     (s1.bypass ? 8'd0 : s1.amt),
      .stype   (s1.stype),
      .c_in    (s1.c_in),
      .rrx     (s1.rrx && !s1.bypass),
      .out     (core_out),
      .cout    (core_cout)
    );

    // Output register only moves when empty or draining, so data holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        out_valid  <= 1'b0;
        out        <= '0;
        shift_cout <= 1'b0;
        out_kind   <= '0;
      end else if (flush) begin
        out_valid <= 1'b0;
      end else if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out        <= core_out;
          shift_cout <= core_cout;
          out_kind   <= s1.kind;
        end
      end
    end
  end

endmodule

// File: doc/arm_operand2_pipe.md
# arm_operand2_pipe

Pipelined, handshaked operand-2 shifter / immediate extender for the ARM datapath. It sits between register-file read and the ALU/address adder. It adds register-specified shifts, full ARM semantics for shift amounts ≥32, RRX, a flush for taken branches, and a configurable one- or two-stage pipeline.

## Interface
Parameters:
- PIPE, 2, register stages (1 or 2); other values are illegal and halt elaboration with an error
- DATA_W, 32, datapath width; only 32 is supported, and the parameter exists for package-wide consistency

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all in-flight entries
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- ir  in  32  instruction word
- rm  in  32  Rm operand
- rs  in  32  Rs operand (only rs[7:0] used)
- c_in  in  1  current CPSR C
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out  out  32  shifted / extended operand
- shift_cout  out  1  shifter carry-out
- out_kind  out  3  ir[27:25] of the result, for downstream muxing

## Operation
Decode is on ir[27:25]. n is the shift amount and rm is the operand.
- **000, ir[4]=0 (immediate shift):** n=ir[11:7], type=ir[6:5].
  - LSL: #0 gives out=rm, c=c_in. Otherwise out=rm<<n, c=rm[32-n].
  - LSR: #0 encodes 32, giving out=0, c=rm[31]. Otherwise c=rm[n-1].
  - ASR: #0 encodes 32, giving out={32{rm[31]}}, c=rm[31]. Otherwise arithmetic shift with c=rm[n-1].
  - ROR: #0 is RRX, giving out={c_in,rm[31:1]}, c=rm[0]. Otherwise rotate with c=rm[n-1].
- **000, ir[4]=1, ir[7]=0 (register shift):** n=rs[7:0].
  - n=0, any type: out=rm, c=c_in.
  - LSL: n=32 gives out=0, c=rm[0]. n>32 gives out=0, c=0.
  - LSR: n=32 gives out=0, c=rm[31]. n>32 gives out=0, c=0.
  - ASR: n≥32 gives out={32{rm[31]}}, c=rm[31].
  - ROR: if n[4:0]=0 (with n≠0), out=rm, c=rm[31]. Otherwise rotate by n[4:0], c=rm[n[4:0]-1].
- **000, ir[4]=1, ir[7]=1 (multiply/extra load-store):** out=rm, c=c_in.
- **001 (rotated immediate):** out=ROR(zext(ir[7:0]), 2*ir[11:8]). If the rotate is 0, c=c_in; otherwise c=out[31].
- **010 (load/store immediate offset):** out=zext(ir[11:0]), c=c_in.
- **011 (scaled register offset):** same rules as the immediate-shift class.
- **101 (branch):** out=sext(ir[23:0])<<2, c=c_in.
- **Other classes:** out=rm, c=c_in.

## Timing
- **Reset:** asserting rst_n low immediately clears all valid bits and zeroes out, shift_cout and out_kind. in_ready is 1 after reset.
- **Latency:** PIPE cycles from acceptance to out_valid when there is no backpressure.
- **Throughput:** one result per cycle.
- **Pipeline with PIPE=2:**
  - S1 registers the decoded type, the 8-bit effective amount, the operand, c_in, the rrx/bypass flags and the kind.
  - S2 registers the barrel-core result.
- **Pipeline with PIPE=1:** decode and the barrel core are combinational into a single output register.
- **Handshake:**
  - A stage loads when it is empty or its contents advance in the same cycle.
  - in_ready = !S1.valid || S1 advances.
  - out, shift_cout and out_kind are held stable while out_valid && !out_ready.
  - in_ready has no combinational dependence on in_valid.
- **Full pipeline:** a new request is accepted in the same cycle the output drains.
- **Flush:**
  - All valid bits clear at the next edge.
  - in_ready=0 while flush=1, so a simultaneous in_valid is dropped.
  - Data registers may retain stale values.
- **Async reset mid-stream:** in-flight results are discarded and never re-emitted.

## Structure
- **Package arm_shift_pkg** holds:
  - the shift-type enum LSL/LSR/ASR/ROR;
  - class codes CLS_DP_REG=3'b000, CLS_DP_IMM=3'b001, CLS_LS_IMM=3'b010, CLS_LS_REG=3'b011, CLS_BR=3'b101;
  - the S1 payload struct.
- **Sub-module arm_barrel_core** is purely combinational.
  - Inputs: operand, amt[7:0], type, c_in, rrx.
  - Outputs: out, cout.
  - It contains every ≥32 and zero-amount rule. Decode maps immediate #0 encodings onto amt=32 or rrx before it.

## Test plan
- **Immediate shift:** ir=0xE1A00FA1 (LSR #31), rm=0x80000000 -> out=0x00000001, c=0 after 2 cycles (PIPE=2).
- **Register shift and RRX:** rs=32 with LSL, rm=0x00000001 -> out=0, c=1. rs=40 -> out=0, c=0. ROR #0 with c_in=1, rm=0x00000003 -> out=0x80000001, c=1.
- **Rotated immediate and branch:** ir=0xE3A004FF (0xFF ROR 8) -> out=0xFF000000, c=1. ir=0xEAFFFFFE -> out=0xFFFFFFF8.
- **Backpressure:**
  - Stream 4 requests with out_ready=0 for 3 cycles.
  - Pipeline fills, then in_ready=0 and out is held stable.
  - After release, results emerge in order with no loss or duplication.
- **Flush:** flush with 2 entries in flight and in_valid=1 -> out_valid=0 next cycle, the new request is not accepted, and the next request completes normally.
- **Async reset:** rst_n pulse mid-stream -> out_valid drops immediately, all outputs are 0, in_ready=1 after release.
